// File: rtl/dsc_host_pkg.sv
// Shared types and constants for the dsc_mul self-test host.
// Holds the FSM state enum, LFSR polynomial, product width and operand slice offsets.
package dsc_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StSettle,
    StCheck,
    StFin
  } host_state_e;

  localparam logic [31:0] LFSR_POLY  = 32'h80200003;
  localparam int unsigned NUM_INPUTS = 4;
  localparam int unsigned PROD_W     = 24;

  // Operand bit offsets inside the 32-bit generator word
  localparam int unsigned A_OFF = 0;
  localparam int unsigned B_OFF = 8;
  localparam int unsigned C_OFF = 16;
  localparam int unsigned D_OFF = 24;

  // One right-shift step of the Galois LFSR
  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR with seed load and step enable.
// A zero seed is replaced by 1 so the register never locks up.
module lfsr32_galois
  import dsc_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;
  logic [31:0] seed_fix;

  always_comb begin
    seed_fix = (seed == 32'h0) ? 32'h1 : seed;
    q_d      = q_q;
    if (load) begin
      q_d = seed_fix;
    end else if (step) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= seed_fix;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dsc_mul_host.sv
// Self-test initiator for the serial deterministic-stochastic multiplier dsc_mul.
// Optional first-failure capture ports are enabled by defining DSC_HOST_FAILCAP_EN.
module dsc_mul_host
  import dsc_host_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 6,
  parameter logic [31:0] LFSR_SEED = 32'h1D872B41,
  parameter int unsigned TIMEOUT_W = 26,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned TESTS_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [TESTS_W-1:0]             num_tests,
  output logic                           busy,
  output logic                           done,
  output logic                           mul_rst,
  output logic                           mul_en,
  output logic [NUM_BITS-1:0]            mul_a,
  output logic [NUM_BITS-1:0]            mul_b,
  output logic [NUM_BITS-1:0]            mul_c,
  output logic [NUM_BITS-1:0]            mul_d,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                           mul_ov,
`ifdef DSC_HOST_FAILCAP_EN
  output logic                           fail_valid,
  output logic [NUM_BITS-1:0]            fail_a,
  output logic [NUM_BITS-1:0]            fail_b,
  output logic [NUM_BITS-1:0]            fail_c,
  output logic [NUM_BITS-1:0]            fail_d,
  output logic [PROD_W-1:0]              fail_z,
  output logic [TESTS_W-1:0]             fail_idx,
`endif
  output logic [TESTS_W-1:0]             tests_run,
  output logic [TESTS_W-1:0]             err_count,
  output logic [TESTS_W-1:0]             timeout_count,
  output logic [ACC_W-1:0]               cycle_acc
);

  function automatic logic [TESTS_W-1:0] sat_inc(input logic [TESTS_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  host_state_e state_q, state_d;

  logic [NUM_BITS-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [TESTS_W-1:0]   num_q, num_d;
  logic [TESTS_W-1:0]   tests_q, tests_d;
  logic [TESTS_W-1:0]   err_q, err_d;
  logic [TESTS_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [TIMEOUT_W-1:0] cnt_inc;
  logic [ACC_W:0]       acc_sum;
  logic [PROD_W-1:0]    prod;
  logic                 mismatch;
  logic                 test_err;
  logic                 last_test;
  logic                 lfsr_adv;
  logic [31:0]          lfsr_q;
  logic [31:0]          lfsr_nxt;

`ifdef DSC_HOST_FAILCAP_EN
  logic                fv_q, fv_d;
  logic [NUM_BITS-1:0] fa_q, fa_d, fb_q, fb_d, fc_q, fc_d, fd_q, fd_d;
  logic [PROD_W-1:0]   fz_q, fz_d;
  logic [TESTS_W-1:0]  fidx_q, fidx_d;
`endif

  lfsr32_galois u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (1'b0),
    .seed (LFSR_SEED),
    .step (lfsr_adv),
    .q    (lfsr_q)
  );

  // Operands come from the post-advance value, so look one step ahead
  assign lfsr_nxt = lfsr_step(lfsr_q);

  always_comb begin
    cnt_inc   = cnt_q + 1'b1;
    prod      = PROD_W'(a_q) * PROD_W'(b_q) * PROD_W'(c_q) * PROD_W'(d_q);
    mismatch  = (mul_z != prod);
    test_err  = tmo_q | mismatch;
    last_test = (({1'b0, tests_q} + 1'b1) == {1'b0, num_q});
    acc_sum   = {1'b0, acc_q} + {{(ACC_W + 1 - TIMEOUT_W){1'b0}}, cnt_q};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    num_d     = num_q;
    tests_d   = tests_q;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    lfsr_adv  = 1'b0;
`ifdef DSC_HOST_FAILCAP_EN
    fv_d   = fv_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    fc_d   = fc_q;
    fd_d   = fd_q;
    fz_d   = fz_q;
    fidx_d = fidx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d     = num_tests;
          tests_d   = '0;
          err_d     = '0;
          tmo_cnt_d = '0;
          acc_d     = '0;
`ifdef DSC_HOST_FAILCAP_EN
          fv_d   = 1'b0;
          fa_d   = '0;
          fb_d   = '0;
          fc_d   = '0;
          fd_d   = '0;
          fz_d   = '0;
          fidx_d = '0;
`endif
          state_d = (num_tests == '0) ? StFin : StLoad;
        end
      end
      StLoad: begin
        lfsr_adv = 1'b1;
        a_d      = lfsr_nxt[A_OFF +: NUM_BITS];
        b_d      = lfsr_nxt[B_OFF +: NUM_BITS];
        c_d      = lfsr_nxt[C_OFF +: NUM_BITS];
        d_d      = lfsr_nxt[D_OFF +: NUM_BITS];
        cnt_d    = '0;
        tmo_d    = 1'b0;
        state_d  = StRun;
      end
      StRun: begin
        // The cycle that samples ov is itself counted
        cnt_d = cnt_inc;
        if (mul_ov) begin
          state_d = StSettle;
        end else if (cnt_inc == '1) begin
          tmo_d   = 1'b1;
          state_d = StCheck;
        end
      end
      StSettle: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (test_err) begin
          err_d = sat_inc(err_q);
`ifdef DSC_HOST_FAILCAP_EN
          if (!fv_q) begin
            fv_d   = 1'b1;
            fa_d   = a_q;
            fb_d   = b_q;
            fc_d   = c_q;
            fd_d   = d_q;
            fz_d   = tmo_q ? '0 : mul_z;
            fidx_d = tests_q;
          end
`endif
        end
        if (tmo_q) begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
        end
        acc_d   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        tests_d = sat_inc(tests_q);
        state_d = last_test ? StFin : StLoad;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mul_rst = 1'b1;
    mul_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StLoad, StCheck: begin
        busy = 1'b1;
      end
      StRun, StSettle: begin
        mul_rst = 1'b0;
        mul_en  = 1'b1;
        busy    = 1'b1;
      end
      StFin: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      num_q     <= '0;
      tests_q   <= '0;
      err_q     <= '0;
      tmo_cnt_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      num_q     <= num_d;
      tests_q   <= tests_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef DSC_HOST_FAILCAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q   <= 1'b0;
      fa_q   <= '0;
      fb_q   <= '0;
      fc_q   <= '0;
      fd_q   <= '0;
      fz_q   <= '0;
      fidx_q <= '0;
    end else begin
      fv_q   <= fv_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
      fc_q   <= fc_d;
      fd_q   <= fd_d;
      fz_q   <= fz_d;
      fidx_q <= fidx_d;
    end
  end

  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_c     = fc_q;
  assign fail_d     = fd_q;
  assign fail_z     = fz_q;
  assign fail_idx   = fidx_q;
`endif

  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign mul_c         = c_q;
  assign mul_d         = d_q;
  assign tests_run     = tests_q;
  assign err_count     = err_q;
  assign timeout_count = tmo_cnt_q;
  assign cycle_acc     = acc_q;

endmodule

// File: tb/tb_dsc_mul_host.sv
// Bench for dsc_mul_host: three instances (default, short-timeout/max-operand seed, zero-a seed)
// each driven by a behavioural dsc_mul model; campaigns come from a table plus random rows.
`timescale 1ns/1ps
module tb_dsc_mul_host;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start         [NI];
  logic [15:0] num_tests     [NI];
  logic        busy          [NI];
  logic        done          [NI];
  logic        mul_rst       [NI];
  logic        mul_en        [NI];
  logic [5:0]  mul_a         [NI];
  logic [5:0]  mul_b         [NI];
  logic [5:0]  mul_c         [NI];
  logic [5:0]  mul_d         [NI];
  logic [23:0] mul_z         [NI];
  logic        mul_ov        [NI];
  logic [15:0] tests_run     [NI];
  logic [15:0] err_count     [NI];
  logic [15:0] timeout_count [NI];
  logic [47:0] cycle_acc     [NI];
`ifdef DSC_HOST_FAILCAP_EN
  logic        fail_valid [NI];
  logic [5:0]  fail_a     [NI];
  logic [5:0]  fail_b     [NI];
  logic [5:0]  fail_c     [NI];
  logic [5:0]  fail_d     [NI];
  logic [23:0] fail_z     [NI];
  logic [15:0] fail_idx   [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dsc_mul_host #(
      .NUM_BITS  (6),
      .LFSR_SEED ((g == 1) ? 32'h7E7E7E7E : (g == 2) ? 32'h7E7E7E00 : 32'h1D872B41),
      .TIMEOUT_W ((g == 1) ? 4 : 26),
      .ACC_W     (48),
      .TESTS_W   (16)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start[g]),
      .num_tests     (num_tests[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .mul_rst       (mul_rst[g]),
      .mul_en        (mul_en[g]),
      .mul_a         (mul_a[g]),
      .mul_b         (mul_b[g]),
      .mul_c         (mul_c[g]),
      .mul_d         (mul_d[g]),
      .mul_z         (mul_z[g]),
      .mul_ov        (mul_ov[g]),
`ifdef DSC_HOST_FAILCAP_EN
      .fail_valid    (fail_valid[g]),
      .fail_a        (fail_a[g]),
      .fail_b        (fail_b[g]),
      .fail_c        (fail_c[g]),
      .fail_d        (fail_d[g]),
      .fail_z        (fail_z[g]),
      .fail_idx      (fail_idx[g]),
`endif
      .tests_run     (tests_run[g]),
      .err_count     (err_count[g]),
      .timeout_count (timeout_count[g]),
      .cycle_acc     (cycle_acc[g])
    );
  end

  // Behavioural dsc_mul: ov on the lat-th enabled cycle, z = exact product (+1 on test inj)
  int unsigned lat_r    [NI] = '{default: 1};
  bit          never_r  [NI] = '{default: 1'b0};
  int          inj_r    [NI] = '{default: -1};
  int unsigned en_cnt   [NI] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mul_rst[i]) en_cnt[i] <= 0;
      else if (mul_en[i]) en_cnt[i] <= en_cnt[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      mul_ov[i] = mul_en[i] && !mul_rst[i] && !never_r[i] && (en_cnt[i] == lat_r[i] - 1);
      mul_z[i]  = 24'(int'(mul_a[i]) * int'(mul_b[i]) * int'(mul_c[i]) * int'(mul_d[i]))
                + ((int'(tests_run[i]) == inj_r[i]) ? 24'd1 : 24'd0);
    end
  end

  // Reference operand generator
  logic [31:0] ref_lfsr [NI];

  function automatic logic [31:0] seed_of(input int g);
    return (g == 1) ? 32'h7E7E7E7E : (g == 2) ? 32'h7E7E7E00 : 32'h1D872B41;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int     g;
    int     num;
    int     lat;
    bit     never;
    int     inj;
    bit     poke;
    int     exp_tests;
    int     exp_err;
    int     exp_to;
    longint exp_acc;
  } row_t;

  task automatic run(input row_t r, input int id);
    int          cyc     = 0;
    int          en_seen = 0;
    int          done_at = -1;
    int          tix     = 0;
    bit          prev_en = 1'b0;
    logic [31:0] v;
    logic [23:0] eprod [$];
    lat_r[r.g]   = r.lat;
    never_r[r.g] = r.never;
    inj_r[r.g]   = r.inj;
    @(negedge clk);
    num_tests[r.g] = 16'(r.num);
    start[r.g]     = 1'b1;
    @(negedge clk);
    start[r.g] = 1'b0;
    while (cyc < 3000) begin
      if (done[r.g]) begin
        done_at = cyc;
        break;
      end
      if (mul_en[r.g]) en_seen++;
      if (mul_en[r.g] && !prev_en) begin
        ref_lfsr[r.g] = adv(ref_lfsr[r.g]);
        v = ref_lfsr[r.g];
        chk($sformatf("row%0d test%0d operands", id, tix),
            {mul_a[r.g], mul_b[r.g], mul_c[r.g], mul_d[r.g]},
            {v[5:0], v[13:8], v[21:16], v[29:24]});
        eprod.push_back(24'(int'(v[5:0]) * int'(v[13:8]) * int'(v[21:16]) * int'(v[29:24])));
        tix++;
      end
      start[r.g] = (r.poke && en_seen == 3);
      if (r.poke && en_seen == 3) num_tests[r.g] = 16'd7;
      prev_en = mul_en[r.g];
      @(negedge clk);
      cyc++;
    end
    start[r.g] = 1'b0;
    if (done_at < 0) begin
      chk($sformatf("row%0d done_timeout", id), 0, 1);
    end else begin
      chk($sformatf("row%0d busy_at_done", id), busy[r.g], 0);
      if (r.num == 0) begin
        chk($sformatf("row%0d zero_done_lat_ok", id), (done_at <= 1), 1);
        chk($sformatf("row%0d zero_no_en", id), en_seen, 0);
      end
      @(negedge clk);
      chk($sformatf("row%0d done_single", id), done[r.g], 0);
    end
    chk($sformatf("row%0d tests_seen", id), tix, r.exp_tests);
    chk($sformatf("row%0d tests_run", id), tests_run[r.g], r.exp_tests);
    chk($sformatf("row%0d err_count", id), err_count[r.g], r.exp_err);
    chk($sformatf("row%0d timeout_count", id), timeout_count[r.g], r.exp_to);
    chk($sformatf("row%0d cycle_acc", id), cycle_acc[r.g], r.exp_acc);
`ifdef DSC_HOST_FAILCAP_EN
    if (r.never && r.num > 0) begin
      chk($sformatf("row%0d fail_valid", id), fail_valid[r.g], 1);
      chk($sformatf("row%0d fail_z", id), fail_z[r.g], 0);
      chk($sformatf("row%0d fail_idx", id), fail_idx[r.g], 0);
    end else if (r.inj >= 0 && r.inj < r.num && r.inj < eprod.size()) begin
      chk($sformatf("row%0d fail_valid", id), fail_valid[r.g], 1);
      chk($sformatf("row%0d fail_idx", id), fail_idx[r.g], r.inj);
      chk($sformatf("row%0d fail_z", id), fail_z[r.g], longint'(eprod[r.inj]) + 1);
    end else begin
      chk($sformatf("row%0d fail_valid", id), fail_valid[r.g], 0);
    end
`endif
    inj_r[r.g] = -1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i]     = 1'b0;
      num_tests[i] = '0;
      ref_lfsr[i]  = seed_of(i);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rst_mid_run();
    int cyc  = 0;
    int tst  = 0;
    int runc = 0;
    bit prev = 1'b0;
    bit hit  = 1'b0;
    lat_r[0]   = 10;
    never_r[0] = 1'b0;
    inj_r[0]   = -1;
    @(negedge clk);
    num_tests[0] = 16'd3;
    start[0]     = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < 500 && !hit) begin
      if (mul_en[0]) begin
        if (!prev) begin
          tst++;
          runc = 0;
        end
        runc++;
      end
      prev = mul_en[0];
      if (tst == 2 && runc == 5) begin
        hit = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rst_mid reached 5th RUN cycle of test 2", hit, 1);
    chk("rst_mid tests_run before rst", tests_run[0], 1);
    chk("rst_mid cycle_acc before rst", cycle_acc[0], 10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid mul_rst", mul_rst[0], 1);
    chk("rst_mid mul_en", mul_en[0], 0);
    chk("rst_mid busy", busy[0], 0);
    chk("rst_mid tests_run", tests_run[0], 0);
    chk("rst_mid cycle_acc", cycle_acc[0], 0);
    chk("rst_mid operands", {mul_a[0], mul_b[0], mul_c[0], mul_d[0]}, 0);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) ref_lfsr[i] = seed_of(i);
    @(negedge clk);
  endtask

  initial begin
    row_t rows [$];
    row_t r;

    reset_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset%0d mul_rst", i), mul_rst[i], 1);
      chk($sformatf("reset%0d mul_en", i), mul_en[i], 0);
      chk($sformatf("reset%0d operands", i), {mul_a[i], mul_b[i], mul_c[i], mul_d[i]}, 0);
      chk($sformatf("reset%0d busy", i), busy[i], 0);
      chk($sformatf("reset%0d done", i), done[i], 0);
      chk($sformatf("reset%0d counters", i),
          {tests_run[i], err_count[i], timeout_count[i], cycle_acc[i]}, 0);
    end

    rst_mid_run();

    //           g num lat nev inj poke tests err to acc
    rows.push_back('{0, 3, 10, 0, -1, 0, 3, 0, 0, 30});
    rows.push_back('{0, 4, 7,  0, 1,  0, 4, 1, 0, 28});
    rows.push_back('{1, 1, 3,  0, -1, 0, 1, 0, 0, 3});
    rows.push_back('{1, 2, 1,  1, -1, 0, 2, 2, 2, 30});
    rows.push_back('{2, 1, 5,  0, -1, 0, 1, 0, 0, 5});
    rows.push_back('{0, 0, 4,  0, -1, 0, 0, 0, 0, 0});
    rows.push_back('{0, 2, 4,  0, -1, 1, 2, 0, 0, 8});
    for (int k = 0; k < 4; k++) begin
      r.g     = 0;
      r.num   = int'($urandom_range(1, 5));
      r.lat   = int'($urandom_range(1, 20));
      r.never = 1'b0;
      r.inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, r.num - 1)) : -1;
      r.poke  = 1'b0;
      r.exp_tests = r.num;
      r.exp_err   = (r.inj >= 0) ? 1 : 0;
      r.exp_to    = 0;
      r.exp_acc   = longint'(r.num) * longint'(r.lat);
      rows.push_back(r);
    end

    for (int i = 0; i < rows.size(); i++) begin
      run(rows[i], i);
      if (i == 2) begin
        chk("max operands all 63", {mul_a[1], mul_b[1], mul_c[1], mul_d[1]}, 24'hFFFFFF);
        chk("max product 24-bit", mul_z[1], 15752961);
      end
      if (i == 4) begin
        chk("zero operand a", mul_a[2], 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
